// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states and
// default operation latencies.
`timescale 1ns/1ps
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_core_if.sv
// Control/data bundle between the MD decode stage (master) and mdu_core (slave).
`timescale 1ns/1ps
interface mdu_core_if;
  logic        Start;
  logic        HiLo;
  logic        We;
  logic [1:0]  Op;
  logic        madd;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] Out;

  modport master (output Start, HiLo, We, Op, madd, A, B, input Busy, Out);
  modport slave  (input Start, HiLo, We, Op, madd, A, B, output Busy, Out);
endinterface

// File: rtl/md_calc.sv
// Combinational 64-bit {HI,LO} result for a latched mult/div operation, including
// the divide-by-zero and signed-overflow results and the optional madd accumulate.
`timescale 1ns/1ps
module md_calc
  import md_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  md_op_e      op_i,
  input  logic        madd_i,
  input  logic [63:0] hilo_i,
  output logic [63:0] res_o
);

  logic [63:0]        prod;
  logic signed [31:0] sq;
  logic signed [31:0] sr;

  always_comb begin
    res_o = '0;
    prod  = '0;
    sq    = '0;
    sr    = '0;
    unique case (op_i)
      MD_MULT: begin
        // Sign-extended operands make the low 64 bits the two's-complement product.
        prod  = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
        res_o = prod + (madd_i ? hilo_i : 64'd0);
      end
      MD_MULTU: begin
        res_o = {32'd0, a_i} * {32'd0, b_i};
      end
      MD_DIV: begin
        if (b_i == 32'd0) begin
          res_o = {a_i, 32'hFFFF_FFFF};
        end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
          res_o = {32'd0, 32'h8000_0000};
        end else begin
          sq    = $signed(a_i) / $signed(b_i);
          sr    = $signed(a_i) % $signed(b_i);
          res_o = {sr, sq};
        end
      end
      MD_DIVU: begin
        if (b_i == 32'd0) begin
          res_o = {a_i, 32'hFFFF_FFFF};
        end else begin
          res_o = {a_i % b_i, a_i / b_i};
        end
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu_core.sv
// Multiply/divide unit holding HI/LO: multi-cycle FSM, latency counter and mthi/mtlo.
// Optional madd accumulate is enabled by defining MDU_MADD_EN.
`timescale 1ns/1ps
module mdu_core
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  mdu_core_if.slave  bus
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  md_op_e      op_q, op_d;
  logic        madd_q, madd_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] res;
  logic        madd_in;

`ifdef MDU_MADD_EN
  assign madd_in = bus.madd;
`else
  assign madd_in = 1'b0;
`endif

  md_calc u_calc (
    .a_i    (a_q),
    .b_i    (b_q),
    .op_i   (op_q),
    .madd_i (madd_q),
    .hilo_i ({hi_q, lo_q}),
    .res_o  (res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    madd_d  = madd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Start == 1'b1) begin
          a_d    = bus.A;
          b_d    = bus.B;
          op_d   = md_op_e'(bus.Op);
          // madd only qualifies a signed mult.
          madd_d = madd_in && (bus.Op == MD_MULT);
          if (bus.Op[1]) begin
            state_d = S_DIV;
            cnt_d   = CW'(DIV_CYCLES);
          end else begin
            state_d = S_MUL;
            cnt_d   = CW'(MULT_CYCLES);
          end
        end else if (bus.We == 1'b1) begin
          if (bus.HiLo) lo_d = bus.A;
          else          hi_d = bus.A;
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == CW'(1)) begin
          {hi_d, lo_d} = res;
          state_d      = S_IDLE;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MD_MULTU;
      madd_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      madd_q  <= madd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.Busy = (state_q != S_IDLE);
  assign bus.Out  = bus.HiLo ? lo_q : hi_q;

endmodule

// File: tb/tb_mdu_core.sv
// Bench for mdu_core: directed plan cases then randomized ops against an
// arithmetic reference model of HI/LO.
`timescale 1ns/1ps
module tb_mdu_core;
  import md_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mdu_core_if bus ();

  mdu_core #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [31:0] hi_m, lo_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_calc(input logic [1:0] op, input logic md,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [63:0] hilo);
    longint      sa, sb;
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    case (op)
      2'b01: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
`ifdef MDU_MADD_EN
        if (md) p = p + hilo;
`endif
        return p;
      end
      2'b00: return {32'd0, a} * {32'd0, b};
      2'b11: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic check_hilo(input string tag);
    bus.HiLo = 1'b0;
    #1 chk({tag, " HI"}, bus.Out, hi_m);
    bus.HiLo = 1'b1;
    #1 chk({tag, " LO"}, bus.Out, lo_m);
  endtask

  // inject: 0 none, 1 Start+We during Busy, 2 We alongside the accepted Start
  task automatic run_op(input string tag, input logic [1:0] op, input logic md,
                        input logic [31:0] a, input logic [31:0] b, input int inject);
    logic [63:0] r;
    int n;
    r = ref_calc(op, md, a, b, {hi_m, lo_m});
    n = op[1] ? 10 : 5;
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.madd = md; bus.A = a; bus.B = b;
    bus.HiLo = 1'b1; bus.We = (inject == 2);
    @(negedge clk);
    bus.Start = 1'b0; bus.We = 1'b0;
    for (int k = 1; k <= n; k++) begin
      chk({tag, " busy"}, {31'd0, bus.Busy}, 32'd1);
      chk({tag, " out during busy"}, bus.Out, lo_m);
      if (inject == 1 && k == 2) begin
        bus.Start = 1'b1; bus.We = 1'b1; bus.Op = 2'b00;
        bus.A = 32'h5A5A_5A5A; bus.B = 32'd3;
      end
      @(negedge clk);
      bus.Start = 1'b0; bus.We = 1'b0;
    end
    {hi_m, lo_m} = r;
    chk({tag, " busy low"}, {31'd0, bus.Busy}, 32'd0);
    check_hilo(tag);
  endtask

  task automatic mt(input string tag, input logic sel, input logic [31:0] v);
    @(negedge clk);
    bus.Start = 1'b0; bus.We = 1'b1; bus.HiLo = sel; bus.A = v;
    @(negedge clk);
    bus.We = 1'b0;
    if (sel) lo_m = v; else hi_m = v;
    check_hilo(tag);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bus.Start = 1'b0; bus.We = 1'b0; bus.HiLo = 1'b0; bus.Op = 2'b00;
    bus.madd = 1'b0; bus.A = '0; bus.B = '0;
    hi_m = '0; lo_m = '0;
    rst_n = 1'b0;
    #12;
    chk("reset busy", {31'd0, bus.Busy}, 32'd0);
    check_hilo("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mult -3*5", 2'b01, 1'b0, 32'hFFFF_FFFD, 32'd5, 0);
    chk("mult HI const", hi_m, 32'hFFFF_FFFF);
    chk("mult LO const", lo_m, 32'hFFFF_FFF1);
    run_op("multu", 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("div -7/2", 2'b11, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div LO const", lo_m, 32'hFFFF_FFFD);
    run_op("divu by 0", 2'b10, 1'b0, 32'd7, 32'd0, 0);
    run_op("div by 0", 2'b11, 1'b0, 32'hFFFF_FF00, 32'd0, 0);
    run_op("div ovf", 2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    mt("mtlo", 1'b1, 32'd5);
    mt("mthi", 1'b0, 32'd0);
    run_op("madd", 2'b01, 1'b1, 32'd3, 32'd4, 0);
`ifdef MDU_MADD_EN
    chk("madd LO const", lo_m, 32'h11);
`else
    chk("madd LO const", lo_m, 32'h0C);
`endif

    run_op("start/we mid busy", 2'b01, 1'b0, 32'h1234_5678, 32'h0000_0F0F, 1);
    run_op("start+we same cycle", 2'b10, 1'b0, 32'd1000, 32'd7, 2);

    // reset asserted during the third Busy cycle
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = 2'b01; bus.madd = 1'b0; bus.A = 32'd9; bus.B = 32'd9;
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    hi_m = '0; lo_m = '0;
    #1 chk("reset mid-op busy", {31'd0, bus.Busy}, 32'd0);
    check_hilo("reset mid-op");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mult after reset", 2'b01, 1'b0, 32'hFFFF_0001, 32'h0001_FFFF, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 4) == 0) mt("rand mt", 1'($urandom_range(0, 1)), $urandom);
      else run_op("rand op", rop, 1'($urandom_range(0, 1)), ra, rb, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
